gcd3_job_sched: RTL and testbench

Job scheduler and result collector wrapped around the 3-bit sequential GCD core. Accepts operand pairs over a valid/ready stream into a small FIFO and issues them to the core one at a time with a single-cycle load pulse. Waits a fixed settle window, captures the core result, and presents it on a valid/ready output stream. It is the stage directly upstream (operand feed) and downstream (result capture) of the GCD core.

---
 rtl/gcd3_job_sched_if.sv | 28 ++
 rtl/gcd3_job_sched.sv | 147 ++++++++++++++
 tb/tb_gcd3_job_sched.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd3_job_sched_if.sv
// Stream, core-side and status signals of gcd3_job_sched bundled in one interface.
// slave is the scheduler's view; master is the view of its surroundings (feeder, core, consumer).
interface gcd3_job_sched_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_a;
    logic [2:0] in_b;
    logic [2:0] core_a;
    logic [2:0] core_b;
    logic       core_load;
    logic [2:0] core_c;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_gcd;
    logic [2:0] out_a;
    logic [2:0] out_b;
    logic       busy;

    modport slave (
        input  in_valid, in_a, in_b, core_c, out_ready,
        output in_ready, core_a, core_b, core_load, out_valid, out_gcd, out_a, out_b, busy
    );

    modport master (
        output in_valid, in_a, in_b, core_c, out_ready,
        input  in_ready, core_a, core_b, core_load, out_valid, out_gcd, out_a, out_b, busy
    );
endinterface

// File: rtl/gcd3_job_sched.sv
// Operand FIFO and job sequencer around the 3-bit GCD core; result held until accepted.
// Optional GCD3_JOB_SCHED_ZERO_BYPASS_EN: pairs with a zero operand skip the core (result a|b).
module gcd3_job_sched #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input logic             clk,
    input logic             rst_n,
    gcd3_job_sched_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [5:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [SW-1:0] settle;
    logic          push;
    logic          pop;
    logic [2:0]    head_a;
    logic [2:0]    head_b;
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
    logic          bypass_q;
    logic          head_zero;
`endif

    always_comb begin
        // in_ready already encodes !full, so a full FIFO refuses even when popping
        push   = bus.in_valid && bus.in_ready;
        pop    = (state == IDLE) && (count != '0);
        head_a = mem[rd_ptr][5:3];
        head_b = mem[rd_ptr][2:0];
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
        head_zero = (head_a == 3'd0) || (head_b == 3'd0);
`endif

        count_n = count;
        if (push && !pop) begin
            count_n = count + CW'(1);
        end else if (pop && !push) begin
            count_n = count - CW'(1);
        end

        state_n = state;
        case (state)
            IDLE: if (pop) state_n = LOAD;
            LOAD:
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
                if (bypass_q) state_n = DONE;
                else
`endif
                state_n = RUN;
            RUN:  if (settle == '0) state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            state         <= IDLE;
            settle        <= '0;
            bus.in_ready  <= 1'b0;
            bus.core_a    <= '0;
            bus.core_b    <= '0;
            bus.core_load <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_gcd   <= '0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.busy      <= 1'b0;
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
            bypass_q      <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count        <= count_n;
            state        <= state_n;
            // Status flags are registered from next-state values so they line up with count/state
            bus.in_ready <= (count_n != CW'(DEPTH));
            bus.busy     <= (state_n != IDLE) || (count_n != '0);

            case (state)
                IDLE: begin
                    if (pop) begin
                        bus.core_a <= head_a;
                        bus.core_b <= head_b;
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
                        bus.core_load <= !head_zero;
                        bypass_q      <= head_zero;
`else
                        bus.core_load <= 1'b1;
`endif
                    end
                end
                LOAD: begin
                    bus.core_load <= 1'b0;
                    settle        <= SW'(SETTLE_CYCLES);
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
                    if (bypass_q) begin
                        bus.out_gcd   <= bus.core_a | bus.core_b;
                        bus.out_a     <= bus.core_a;
                        bus.out_b     <= bus.core_b;
                        bus.out_valid <= 1'b1;
                    end
`endif
                end
                RUN: begin
                    if (settle == '0) begin
                        bus.out_gcd   <= bus.core_c;
                        bus.out_a     <= bus.core_a;
                        bus.out_b     <= bus.core_b;
                        bus.out_valid <= 1'b1;
                    end else begin
                        settle <= settle - SW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) bus.out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd3_job_sched.sv
// Directed bench for gcd3_job_sched with a behavioural GCD core and a result scoreboard.
// Latency expectations follow GCD3_JOB_SCHED_ZERO_BYPASS_EN when it is defined.
module tb_gcd3_job_sched;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 8;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] g;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gcd3_job_sched_if bus ();

    gcd3_job_sched #(
        .DEPTH        (DEPTH),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   load_cnt  = 0;
    int   load_cyc  = 0;
    int   last_hs   = -1;
    bit   spacing_on = 1'b0;
    exp_t sb[$];

    function automatic logic [2:0] gcd_ref(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x, y, t;
        x = a;
        y = b;
        while (y != 3'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural core: result appears a few cycles after load, well inside the settle window
    logic [2:0] core_pend;
    int         core_dly = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_load) begin
            core_pend  <= gcd_ref(bus.core_a, bus.core_b);
            core_dly   <= 4;
            bus.core_c <= 3'd0;
            load_cnt   <= load_cnt + 1;
            load_cyc   <= cyc;
        end else if (core_dly != 0) begin
            core_dly <= core_dly - 1;
            if (core_dly == 1) bus.core_c <= core_pend;
        end
    end

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("result_without_job", bus.out_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("out_gcd", bus.out_gcd, mon_e.g);
                check("out_a", bus.out_a, mon_e.a);
                check("out_b", bus.out_b, mon_e.b);
                if (spacing_on && last_hs >= 0) check("result_spacing", cyc - last_hs, SETTLE + 4);
                last_hs = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers (a,b) until accepted; returns after the accepting edge with in_valid still high
    task automatic push(input logic [2:0] a, input logic [2:0] b, output int acc);
        int n;
        exp_t e;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("push_ready_timeout", bus.in_ready, 1);
        tick();
        acc = cyc;
        e.a = a;
        e.b = b;
        e.g = gcd_ref(a, b);
        sb.push_back(e);
    endtask

    task automatic drain;
        int n;
        bus.out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic single(input logic [2:0] a, input logic [2:0] b, input int exp_lat, input int exp_loads);
        int n, t, l0;
        bus.out_ready = 1'b0;
        l0 = load_cnt;
        push(a, b, t);
        bus.in_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check("result_latency", n, exp_lat);
        check("direct_gcd", bus.out_gcd, gcd_ref(a, b));
        check("core_a_held", bus.core_a, a);
        check("core_b_held", bus.core_b, b);
        repeat (3) tick();
        check("stall_holds_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("valid_clears_on_accept", bus.out_valid, 0);
        bus.out_ready = 1'b0;
        check("load_pulses", load_cnt - l0, exp_loads);
        if (exp_loads == 1) check("load_timing", load_cyc - t, 1);
    endtask

    initial begin
        int   t, n, l0;
        logic seen_valid;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_core_load", bus.core_load, 0);
        check("rst_out_gcd", bus.out_gcd, 0);
        rst_n = 1'b1;
        tick();
        check("in_ready_after_rst", bus.in_ready, 1);

        // Single job through the core
        single(3'd6, 3'd4, SETTLE + 3, 1);
        single(3'd7, 3'd1, SETTLE + 3, 1);

        // Backpressure: one job parked in DONE, FIFO fills, 6th offer held
        bus.out_ready = 1'b0;
        push(3'd6, 3'd4, t);
        push(3'd5, 3'd5, t);
        push(3'd3, 3'd6, t);
        push(3'd7, 3'd2, t);
        push(3'd4, 3'd2, t);
        check("in_ready_full", bus.in_ready, 0);
        bus.in_a = 3'd6;
        bus.in_b = 3'd3;
        repeat (12) tick();
        check("full_holds_ready_low", bus.in_ready, 0);
        check("done_stalled", bus.out_valid, 1);
        check("busy_stalled", bus.busy, 1);
        // Accepting the result lets IDLE pop while the held offer is refused on that same edge
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.core_load && n < 20) begin
            tick();
            n++;
        end
        check("pop_load_seen", bus.core_load, 1);
        check("ready_after_full_pop", bus.in_ready, 1);
        tick();
        begin
            exp_t e;
            e.a = 3'd6;
            e.b = 3'd3;
            e.g = gcd_ref(3'd6, 3'd3);
            sb.push_back(e);
        end
        bus.in_valid = 1'b0;
        drain();
        check("drain_empty", sb.size(), 0);

        // Streaming with out_ready high: fixed result spacing
        bus.out_ready = 1'b1;
        last_hs    = -1;
        spacing_on = 1'b1;
        push(3'd7, 3'd7, t);
        push(3'd6, 3'd3, t);
        push(3'd5, 3'd3, t);
        bus.in_valid = 1'b0;
        drain();
        spacing_on = 1'b0;
        check("stream_empty", sb.size(), 0);

        // Reset in the middle of RUN with two jobs still queued
        bus.out_ready = 1'b1;
        push(3'd1, 3'd2, t);
        push(3'd2, 3'd4, t);
        push(3'd3, 3'd3, t);
        bus.in_valid = 1'b0;
        repeat (3) tick();
        check("busy_in_run", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        sb.delete();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready_rise", bus.in_ready, 1);
        l0 = load_cnt;
        seen_valid = 1'b0;
        repeat (30) begin
            tick();
            seen_valid = seen_valid | bus.out_valid;
        end
        check("no_stale_result", seen_valid, 0);
        check("no_load_after_flush", load_cnt - l0, 0);
        check("idle_after_flush", bus.busy, 0);

        // Zero operand
`ifdef GCD3_JOB_SCHED_ZERO_BYPASS_EN
        single(3'd0, 3'd5, 2, 0);
`else
        single(3'd0, 3'd5, SETTLE + 3, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
